// File: rtl/result_streamer_if.sv
// Core-to-streamer and streamer-to-DMA signal bundle for result_streamer.
// slave = the streamer itself, master = the core/consumer side driving it.
interface result_streamer_if #(
  parameter int DIM   = 1023,
  parameter int OUT_W = 32
);
  logic             store;
  logic [DIM:0]     core_result;
  logic             last;
  logic             stream_v;
  logic [OUT_W-1:0] stream_d;
  logic             stream_last;
  logic             stream_ready;
  logic             overflow;
  logic             busy;

  modport slave (
    input  store, core_result, last, stream_ready,
    output stream_v, stream_d, stream_last, overflow, busy
  );

  modport master (
    output store, core_result, last, stream_ready,
    input  stream_v, stream_d, stream_last, overflow, busy
  );
endinterface

// File: rtl/result_streamer.sv
// Captures result vectors and batch markers into a small FIFO and serializes them as OUT_W-bit
// words closed by a vector-count trailer. Optional RESULT_CHK_EN adds an XOR check field to the trailer.
module result_streamer #(
  parameter int DIM   = 1023,
  parameter int OUT_W = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             run,
  result_streamer_if.slave bus
);
  localparam int VW  = DIM + 1;
  localparam int EW  = VW + 1;
  localparam int NW  = VW / OUT_W;
  localparam int WCW = (NW > 1) ? $clog2(NW) : 1;
  localparam int PW  = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_VEC  = 2'd1;
  localparam logic [1:0] S_TRL  = 2'd2;

  localparam logic [WCW-1:0] WC_LAST   = WCW'(NW - 1);
  localparam logic [PW:0]    FIFO_FULL = DEPTH[PW:0];

  function automatic logic [15:0] f_sat_inc(input logic [15:0] v);
    f_sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [OUT_W-1:0] f_trailer(input logic [15:0] cnt, input logic [15:0] chk);
    f_trailer        = '0;
    f_trailer[15:0]  = cnt;
    f_trailer[31:16] = chk;
  endfunction

`ifdef RESULT_CHK_EN
  function automatic logic [15:0] f_fold(input logic [OUT_W-1:0] word);
    f_fold = word[31:16] ^ word[15:0];
  endfunction
`endif

  logic [EW-1:0]    r_mem [DEPTH];
  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;
  logic [1:0]       r_state;
  logic [WCW-1:0]   r_wcnt;
  logic [15:0]      r_vec_count;
  logic             r_stream_v;
  logic [OUT_W-1:0] r_stream_d;
  logic             r_stream_last;
  logic             r_overflow;
  logic             r_busy;
  logic [EW-1:0]    r_stg0;
  logic [EW-1:0]    r_stg1;
  logic [1:0]       r_stg_cnt;

  logic [EW-1:0]    w_ev [3];
  logic [2:0]       w_base;
  logic [2:0]       w_lt_idx;
  logic [2:0]       w_n;
  logic [1:0]       w_stg_cnt_n;
  logic             w_push_req;
  logic             w_push_ok;
  logic             w_drop;

  logic [PW:0]      w_count;
  logic             w_empty;
  logic             w_full;
  logic             w_multi;
  logic [PW-1:0]    w_wr_idx;
  logic [PW-1:0]    w_rd_idx;
  logic [PW-1:0]    w_nx_idx;
  logic [EW-1:0]    w_head;
  logic [EW-1:0]    w_load_ent;
  logic [PW:0]      w_wr_ptr_n;
  logic [PW:0]      w_rd_ptr_n;

  logic             w_in_vec;
  logic             w_in_trl;
  logic             w_idle;
  logic             w_accept;
  logic             w_vec_done;
  logic             w_trl_done;
  logic             w_pop;
  logic             w_load;
  logic [WCW-1:0]   w_wcnt_inc;
  logic [OUT_W-1:0] w_head_word;
  logic [15:0]      w_vc_eff;
  logic [15:0]      w_chk_eff;

  logic [1:0]       w_state_n;
  logic [WCW-1:0]   w_wcnt_n;
  logic             w_v_n;
  logic [OUT_W-1:0] w_d_n;
  logic             w_last_n;
  logic             w_busy_n;

  // Events this cycle in arrival order: staged leftovers, then store, then last.
  assign w_base   = {1'b0, r_stg_cnt};
  assign w_lt_idx = w_base + {2'b00, bus.store};
  assign w_n      = w_lt_idx + {2'b00, bus.last};

  // Order the candidate pushes; only slot 0 reaches the FIFO this cycle.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      if (3'(k) < w_base) begin
        w_ev[k] = (k == 0) ? r_stg0 : r_stg1;
      end else if (bus.store && (3'(k) == w_base)) begin
        w_ev[k] = {1'b0, bus.core_result};
      end else if (bus.last && (3'(k) == w_lt_idx)) begin
        w_ev[k] = {1'b1, {VW{1'b0}}};
      end else begin
        w_ev[k] = '0;
      end
    end
  end

  // Whatever is not pushed now waits in the staging slots.
  always_comb begin
    case (w_n)
      3'd0, 3'd1: w_stg_cnt_n = 2'd0;
      3'd2:       w_stg_cnt_n = 2'd1;
      default:    w_stg_cnt_n = 2'd2;
    endcase
  end

  assign w_count  = r_wr_ptr - r_rd_ptr;
  assign w_empty  = (w_count == '0);
  assign w_full   = (w_count == FIFO_FULL);
  assign w_multi  = (w_count > {{PW{1'b0}}, 1'b1});
  assign w_wr_idx = r_wr_ptr[PW-1:0];
  assign w_rd_idx = r_rd_ptr[PW-1:0];
  assign w_nx_idx = w_rd_idx + PW'(1);
  assign w_head   = r_mem[w_rd_idx];

  assign w_push_req = (w_n != 3'd0);
  assign w_push_ok  = w_push_req && (!w_full || w_pop);
  assign w_drop     = (w_push_req && !w_push_ok) || (w_n == 3'd4);

  assign w_in_vec   = (r_state == S_VEC);
  assign w_in_trl   = (r_state == S_TRL);
  assign w_idle     = !w_in_vec && !w_in_trl;
  assign w_accept   = r_stream_v && bus.stream_ready;
  assign w_vec_done = w_accept && w_in_vec && (r_wcnt == WC_LAST);
  assign w_trl_done = w_accept && w_in_trl;
  assign w_pop      = w_vec_done || w_trl_done;
  // Back-to-back entries skip IDLE when the next head is already stored.
  assign w_load     = (w_idle && !w_empty) || (w_pop && w_multi);
  assign w_load_ent = w_idle ? w_head : r_mem[w_nx_idx];
  assign w_wcnt_inc = r_wcnt + WCW'(1);
  assign w_head_word = w_head[int'(w_wcnt_inc)*OUT_W +: OUT_W];

  assign w_wr_ptr_n = r_wr_ptr + {{PW{1'b0}}, w_push_ok};
  assign w_rd_ptr_n = r_rd_ptr + {{PW{1'b0}}, w_pop};

  // Vector count as seen after this edge, so a bypassed trailer includes the vector just finished.
  always_comb begin
    if (w_trl_done) begin
      w_vc_eff = 16'd0;
    end else if (w_vec_done) begin
      w_vc_eff = f_sat_inc(r_vec_count);
    end else begin
      w_vc_eff = r_vec_count;
    end
  end

`ifdef RESULT_CHK_EN
  logic [15:0] r_chk;

  // Check accumulator as seen after this edge.
  always_comb begin
    if (w_trl_done) begin
      w_chk_eff = 16'd0;
    end else if (w_accept && w_in_vec) begin
      w_chk_eff = r_chk ^ f_fold(r_stream_d);
    end else begin
      w_chk_eff = r_chk;
    end
  end

  // Check accumulator register.
  always_ff @(posedge clk or negedge run) begin
    if (!run) begin
      r_chk <= 16'd0;
    end else begin
      r_chk <= w_chk_eff;
    end
  end
`else
  assign w_chk_eff = 16'd0;
`endif

  // Output word sequencing.
  always_comb begin
    w_state_n = r_state;
    w_wcnt_n  = r_wcnt;
    w_v_n     = r_stream_v;
    w_d_n     = r_stream_d;
    w_last_n  = r_stream_last;
    if (w_load) begin
      w_v_n    = 1'b1;
      w_wcnt_n = '0;
      if (w_load_ent[EW-1]) begin
        w_state_n = S_TRL;
        w_d_n     = f_trailer(w_vc_eff, w_chk_eff);
        w_last_n  = 1'b1;
      end else begin
        w_state_n = S_VEC;
        w_d_n     = w_load_ent[OUT_W-1:0];
        w_last_n  = 1'b0;
      end
    end else if (w_pop || (w_idle && r_stream_v)) begin
      w_state_n = S_IDLE;
      w_wcnt_n  = '0;
      w_v_n     = 1'b0;
      w_d_n     = '0;
      w_last_n  = 1'b0;
    end else if (w_accept && w_in_vec) begin
      w_wcnt_n = w_wcnt_inc;
      w_d_n    = w_head_word;
    end else begin
      w_state_n = r_state;
    end
  end

  assign w_busy_n = (w_wr_ptr_n != w_rd_ptr_n) || (w_state_n != S_IDLE) || (w_stg_cnt_n != 2'd0);

  // FIFO storage; contents are don't-care until written, the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[w_wr_idx] <= w_ev[0];
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge run) begin
    if (!run) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_state       <= S_IDLE;
      r_wcnt        <= '0;
      r_vec_count   <= 16'd0;
      r_stream_v    <= 1'b0;
      r_stream_d    <= '0;
      r_stream_last <= 1'b0;
      r_overflow    <= 1'b0;
      r_busy        <= 1'b0;
      r_stg0        <= '0;
      r_stg1        <= '0;
      r_stg_cnt     <= 2'd0;
    end else begin
      r_wr_ptr      <= w_wr_ptr_n;
      r_rd_ptr      <= w_rd_ptr_n;
      r_state       <= w_state_n;
      r_wcnt        <= w_wcnt_n;
      r_vec_count   <= w_vc_eff;
      r_stream_v    <= w_v_n;
      r_stream_d    <= w_d_n;
      r_stream_last <= w_last_n;
      r_overflow    <= r_overflow || w_drop;
      r_busy        <= w_busy_n;
      r_stg0        <= w_ev[1];
      r_stg1        <= w_ev[2];
      r_stg_cnt     <= w_stg_cnt_n;
    end
  end

  assign bus.stream_v    = r_stream_v;
  assign bus.stream_d    = r_stream_d;
  assign bus.stream_last = r_stream_last;
  assign bus.overflow    = r_overflow;
  assign bus.busy        = r_busy;
endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer: a queue-level model of the word stream checked every cycle,
// plus literal expectations on capture order, latency and trailer values.
module tb_result_streamer;
  localparam int DIM   = 1023;
  localparam int OUT_W = 32;
  localparam int DEPTH = 4;
  localparam int NW    = (DIM + 1) / OUT_W;
  localparam bit CHK_ON =
`ifdef RESULT_CHK_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk = 1'b0;
  logic run = 1'b0;

  result_streamer_if #(.DIM(DIM), .OUT_W(OUT_W)) bus ();

  result_streamer #(.DIM(DIM), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .run (run),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [OUT_W:0]  exp_q [$];
  int              fifo_q [$];
  logic [DIM+1:0]  pend_q [$];
  logic [OUT_W:0]  cap_q [$];
  int              cap_cyc [$];
  logic [15:0]     m_cnt  = 16'd0;
  logic [15:0]     m_chk  = 16'd0;
  logic            m_ovf  = 1'b0;
  logic            m_busy = 1'b0;
  logic            prev_hold = 1'b0;
  logic [OUT_W:0]  prev_word = '0;
  logic [DIM:0]    vec_inc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    exp_q.delete();
    fifo_q.delete();
    pend_q.delete();
    m_cnt = 16'd0; m_chk = 16'd0; m_ovf = 1'b0; m_busy = 1'b0;
    prev_hold = 1'b0;
  endtask

  // An entry accepted into the FIFO will produce exactly these words, in this order.
  task automatic model_push(input logic [DIM+1:0] e);
    logic [OUT_W-1:0] w;
    if (e[DIM+1]) begin
      w = '0;
      w[15:0]  = m_cnt;
      w[31:16] = CHK_ON ? m_chk : 16'h0000;
      exp_q.push_back({1'b1, w});
      fifo_q.push_back(1);
      m_cnt = 16'd0;
      m_chk = 16'd0;
    end else begin
      for (int k = 0; k < NW; k++) begin
        w = e[k*OUT_W +: OUT_W];
        exp_q.push_back({1'b0, w});
        m_chk = m_chk ^ w[31:16] ^ w[15:0];
      end
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      fifo_q.push_back(NW);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Per-cycle compare, then advance the model across the coming clock edge.
  initial forever begin
    logic [DIM+1:0] e;
    @(negedge clk);
    if (!run) begin
      check("rst_v", bus.stream_v, 1'b0);
      check("rst_d", bus.stream_d, '0);
      check("rst_last", bus.stream_last, 1'b0);
      check("rst_ovf", bus.overflow, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      model_clear();
    end else begin
      check("ovf", bus.overflow, m_ovf);
      check("busy", bus.busy, m_busy);
      if (prev_hold) check("stall_hold", {bus.stream_v, bus.stream_last, bus.stream_d}, {1'b1, prev_word});
      if (bus.stream_v) begin
        check("v_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check("word", {bus.stream_last, bus.stream_d}, exp_q[0]);
      end
      prev_hold = bus.stream_v && !bus.stream_ready;
      prev_word = {bus.stream_last, bus.stream_d};
      if (bus.stream_v && bus.stream_ready) begin
        cap_q.push_back({bus.stream_last, bus.stream_d});
        cap_cyc.push_back(cyc);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (fifo_q.size() > 0) begin
          fifo_q[0] = fifo_q[0] - 1;
          if (fifo_q[0] == 0) void'(fifo_q.pop_front());
        end
      end
      if (bus.store) pend_q.push_back({1'b0, bus.core_result});
      if (bus.last)  pend_q.push_back({1'b1, {(DIM+1){1'b0}}});
      if (pend_q.size() > 0) begin
        e = pend_q.pop_front();
        if (fifo_q.size() < DEPTH) model_push(e);
        else m_ovf = 1'b1;
      end
      while (pend_q.size() > 2) begin
        void'(pend_q.pop_back());
        m_ovf = 1'b1;
      end
      m_busy = (fifo_q.size() > 0) || (pend_q.size() > 0);
    end
  end

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || bus.busy) && k < budget) begin
      tick();
      k++;
    end
    check("drain_done", (exp_q.size() == 0) && !bus.busy, 1'b1);
  endtask

  task automatic cap_clear();
    cap_q.delete();
    cap_cyc.delete();
  endtask

  task automatic check_inc_batch(input string tag);
    check({tag, "_nwords"}, cap_q.size(), NW + 1);
    if (cap_q.size() == NW + 1) begin
      for (int k = 0; k < NW; k++) check({tag, "_word"}, cap_q[k], {1'b0, OUT_W'(k)});
      check({tag, "_trailer"}, cap_q[NW], {1'b1, 32'h0000_0001});
    end
  endtask

  initial begin
    int c0;
    logic [3:0] nib;
    bus.store = 1'b0; bus.last = 1'b0; bus.core_result = '0; bus.stream_ready = 1'b0;
    for (int k = 0; k < NW; k++) vec_inc[k*OUT_W +: OUT_W] = OUT_W'(k);

    // Reset held with toggling inputs, then quiet release.
    for (int i = 0; i < 6; i++) begin
      tick();
      bus.store = i[0]; bus.last = ~i[0]; bus.stream_ready = i[1];
      bus.core_result = {32{32'(i)}};
    end
    tick();
    bus.store = 1'b0; bus.last = 1'b0; bus.stream_ready = 1'b1;
    run = 1'b1;
    repeat (6) tick();
    check("post_rst_v", bus.stream_v, 1'b0);
    check("post_rst_busy", bus.busy, 1'b0);

    // One vector plus marker, consumer always ready.
    cap_clear();
    c0 = cyc;
    bus.store = 1'b1; bus.core_result = vec_inc; tick();
    bus.store = 1'b0; bus.last = 1'b1; tick();
    bus.last = 1'b0;
    drain(200);
    check_inc_batch("t2");
    if (cap_cyc.size() == NW + 1) begin
      check("t2_latency", cap_cyc[0] - c0, 2);
      check("t2_no_bubble", cap_cyc[NW] - cap_cyc[0], NW);
    end

    // Same batch with ready toggling every cycle.
    cap_clear();
    bus.stream_ready = 1'b0;
    bus.store = 1'b1; tick();
    bus.store = 1'b0; bus.last = 1'b1; bus.stream_ready = 1'b1; tick();
    bus.last = 1'b0;
    for (int k = 0; k < 120 && (exp_q.size() != 0 || bus.busy); k++) begin
      bus.stream_ready = ~bus.stream_ready;
      tick();
    end
    bus.stream_ready = 1'b1;
    drain(50);
    check_inc_batch("t3");

    // Marker alone gives an all-zero trailer.
    cap_clear();
    bus.last = 1'b1; tick();
    bus.last = 1'b0;
    drain(20);
    check("t5_nwords", cap_q.size(), 1);
    if (cap_q.size() == 1) check("t5_trailer", cap_q[0], {1'b1, 32'h0000_0000});

    // Five stores against a stalled consumer: the fifth and the marker are dropped.
    cap_clear();
    bus.stream_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      nib = 4'hA + 4'(k);
      bus.store = 1'b1; bus.core_result = {256{nib}}; tick();
      bus.store = 1'b0;
      check("t4_ovf_step", bus.overflow, k == 4);
    end
    bus.last = 1'b1; tick();
    bus.last = 1'b0;
    check("t4_ovf_sticky", bus.overflow, 1'b1);
    bus.stream_ready = 1'b1;
    drain(400);
    check("t4_nwords", cap_q.size(), 4 * NW);
    if (cap_q.size() == 4 * NW) begin
      check("t4_first", cap_q[0], {1'b0, 32'hAAAA_AAAA});
      check("t4_b", cap_q[NW], {1'b0, 32'hBBBB_BBBB});
      check("t4_c", cap_q[2*NW], {1'b0, 32'hCCCC_CCCC});
      check("t4_final", cap_q[4*NW-1], {1'b0, 32'hDDDD_DDDD});
    end
    check("t4_busy", bus.busy, 1'b0);

    // Store+last together, then reset while word 10 is on the bus.
    cap_clear();
    bus.store = 1'b1; bus.last = 1'b1; bus.core_result = vec_inc; tick();
    bus.store = 1'b0; bus.last = 1'b0;
    for (int k = 0; k < 50 && cap_q.size() < 10; k++) tick();
    run = 1'b0;
    #1;
    check("t6_v_on_rst", bus.stream_v, 1'b0);
    repeat (3) tick();
    run = 1'b1;
    repeat (10) tick();
    check("t6_nwords", cap_q.size(), 10);
    if (cap_q.size() == 10) check("t6_word9", cap_q[9], {1'b0, 32'h0000_0009});
    check("t6_busy", bus.busy, 1'b0);
    check("t6_v", bus.stream_v, 1'b0);
    check("t6_ovf", bus.overflow, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
